// File: rtl/text_vram_axi_regs.sv
// AXI4-Lite register file holding 600 text VRAM words plus one color control word.
// A dedicated registered read port serves the HDMI color mapper.
module text_vram_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int NUM_REGS           = 601
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [9:0]                      vram_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   vram_data,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_word
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam int ARR_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [9:0] LAST_VIDX = 10'(NUM_REGS - 1);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] { W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP } wstate_t;
  typedef enum logic { R_IDLE, R_DATA } rstate_t;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

  wstate_t wstate, wnext;
  rstate_t rstate, rnext;
  logic live;

  logic [IDX_W-1:0] aw_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] w_strb;
  logic aw_hs, w_hs, ar_hs;
  logic lat_a, lat_d, commit;
  logic [IDX_W-1:0] c_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] c_data;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] c_strb;
  logic [IDX_W-1:0] ar_idx;

  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign ar_idx    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign ctrl_word = regs[NUM_REGS-1];

  // The commit source mixes latched and live bus fields depending on which half arrived first.
  always_comb begin
    wnext  = wstate;
    lat_a  = 1'b0;
    lat_d  = 1'b0;
    commit = 1'b0;
    c_idx  = aw_idx;
    c_data = w_data;
    c_strb = w_strb;
    S_AXI_AWREADY = live && (wstate == W_IDLE || wstate == W_HAVE_D);
    S_AXI_WREADY  = live && (wstate == W_IDLE || wstate == W_HAVE_A);
    S_AXI_BVALID  = (wstate == W_RESP);
    aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    case (wstate)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          c_idx  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
          c_data = S_AXI_WDATA;
          c_strb = S_AXI_WSTRB;
          wnext  = W_RESP;
        end else if (aw_hs) begin
          lat_a = 1'b1;
          wnext = W_HAVE_A;
        end else if (w_hs) begin
          lat_d = 1'b1;
          wnext = W_HAVE_D;
        end
      end
      W_HAVE_A: begin
        if (w_hs) begin
          commit = 1'b1;
          c_data = S_AXI_WDATA;
          c_strb = S_AXI_WSTRB;
          wnext  = W_RESP;
        end
      end
      W_HAVE_D: begin
        if (aw_hs) begin
          commit = 1'b1;
          c_idx  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
          wnext  = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) wnext = W_IDLE;
      end
      default: wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[ARR_W'(i)] <= '0;
      live        <= 1'b0;
      wstate      <= W_IDLE;
      aw_idx      <= '0;
      w_data      <= '0;
      w_strb      <= '0;
      S_AXI_BRESP <= RESP_OKAY;
    end else begin
      live   <= 1'b1;
      wstate <= wnext;
      if (lat_a) aw_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      if (lat_d) begin
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (commit) begin
        S_AXI_BRESP <= (c_idx <= LAST_IDX) ? RESP_OKAY : RESP_SLVERR;
        if (c_idx <= LAST_IDX) begin
          for (int unsigned b = 0; b < C_S_AXI_DATA_WIDTH/8; b++)
            if (c_strb[b]) regs[ARR_W'(c_idx)][8*b +: 8] <= c_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rnext = rstate;
    S_AXI_ARREADY = live && (rstate == R_IDLE);
    S_AXI_RVALID  = (rstate == R_DATA);
    ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    case (rstate)
      R_IDLE:  if (ar_hs) rnext = R_DATA;
      R_DATA:  if (S_AXI_RREADY) rnext = R_IDLE;
      default: rnext = R_IDLE;
    endcase
  end

  // Read data is captured from the pre-commit array, so a same-edge write returns the old value.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      rstate      <= R_IDLE;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
      vram_data   <= '0;
    end else begin
      rstate <= rnext;
      if (ar_hs) begin
        S_AXI_RDATA <= (ar_idx <= LAST_IDX) ? regs[ARR_W'(ar_idx)] : '0;
        S_AXI_RRESP <= (ar_idx <= LAST_IDX) ? RESP_OKAY : RESP_SLVERR;
      end
      vram_data <= (vram_addr <= LAST_VIDX) ? regs[ARR_W'(vram_addr)] : '0;
    end
  end

endmodule

// File: tb/tb_text_vram_axi_regs.sv
// Scoreboard bench for text_vram_axi_regs: stimulus pushes expected B/R beats,
// a forked monitor pops and compares them as the DUT presents them.
module tb_text_vram_axi_regs;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [11:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] rdata;
  logic [9:0]  vram_addr;
  logic [31:0] vram_data, ctrl_word;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic [1:0] bq [$];
  r_exp_t     rq [$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  text_vram_axi_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(12),
    .NUM_REGS(601)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .vram_addr(vram_addr), .vram_data(vram_data), .ctrl_word(ctrl_word)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    r_exp_t re;
    forever begin
      @(negedge clk);
      if (aresetn) begin
        if (bvalid && bready) begin
          if (bq.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL b_unexpected: got bresp %0b, expected no beat", bresp);
          end else chk("bresp", 32'(bresp), 32'(bq.pop_front()));
        end
        if (rvalid && rready) begin
          if (rq.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL r_unexpected: got rdata 0x%08h, expected no beat", rdata);
          end else begin
            re = rq.pop_front();
            chk("rdata", rdata, re.data);
            chk("rresp", 32'(rresp), 32'(re.resp));
          end
        end
      end
    end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input logic [1:0] exp);
    bit aw_done = 0, w_done = 0, aw_t, w_t;
    int c = 0;
    bq.push_back(exp);
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && c < 50) begin
      awvalid = !aw_done && (c >= aw_dly);
      wvalid  = !w_done && (c >= w_dly);
      aw_t = awvalid && awready;
      w_t  = wvalid && wready;
      tick();
      aw_done |= aw_t;
      w_done  |= w_t;
      c++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (!(aw_done && w_done)) timeout("write_handshake");
  endtask

  task automatic wait_b();
    for (int c = 0; c < 30; c++) begin
      if (bvalid && bready) begin
        tick();
        return;
      end
      tick();
    end
    timeout("b_beat");
  endtask

  task automatic issue_ar(input logic [11:0] a);
    bit t;
    araddr = a;
    arvalid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      t = arready;
      tick();
      if (t) begin
        arvalid = 1'b0;
        return;
      end
    end
    arvalid = 1'b0;
    timeout("ar_handshake");
  endtask

  task automatic wait_r();
    for (int c = 0; c < 30; c++) begin
      if (rvalid && rready) begin
        tick();
        return;
      end
      tick();
    end
    timeout("r_beat");
  endtask

  task automatic axi_read(input logic [11:0] a, input logic [31:0] d, input logic [1:0] resp);
    rq.push_back('{data: d, resp: resp});
    issue_ar(a);
    wait_r();
  endtask

  initial begin
    aresetn = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wdata = '0; wstrb = '0;
    bready = 1'b1; rready = 1'b1;
    vram_addr = 10'd5;
    fork monitor(); join_none

    // reset held 3 cycles
    tick();
    chk("awready_in_reset", 32'(awready), 32'd0);
    tick(); tick();
    aresetn = 1'b1;
    tick();
    chk("ready_after_reset", {29'd0, awready, wready, arready}, 32'h7);
    chk("valids_after_reset", {30'd0, bvalid, rvalid}, 32'd0);
    chk("ctrl_after_reset", ctrl_word, 32'd0);
    chk("vram_after_reset", vram_data, 32'd0);

    // AW before W
    axi_write(12'h010, 32'h8341_4241, 4'hF, 1, 3, 2'b00);
    wait_b();
    axi_read(12'h010, 32'h8341_4241, 2'b00);
    vram_addr = 10'd4;
    tick();
    chk("vram_word4", vram_data, 32'h8341_4241);
    vram_addr = 10'd700;
    tick();
    chk("vram_out_of_range", vram_data, 32'd0);

    // W before AW
    axi_write(12'h014, 32'hCAFE_0005, 4'hF, 2, 0, 2'b00);
    wait_b();
    axi_read(12'h014, 32'hCAFE_0005, 2'b00);

    // byte strobes with B back-pressure
    axi_write(12'h01C, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b00);
    wait_b();
    bready = 1'b0;
    axi_write(12'h01C, 32'h1234_5678, 4'b0101, 0, 0, 2'b00);
    awaddr = 12'h020; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bvalid_held", 32'(bvalid), 32'd1);
      chk("no_accept_in_resp", {30'd0, awready, wready}, 32'd0);
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    wait_b();
    axi_read(12'h01C, 32'hFF34_FF78, 2'b00);
    axi_read(12'h020, 32'h0000_0000, 2'b00);

    // control word and out-of-range
    axi_write(12'h960, 32'h01E0_3C00, 4'hF, 0, 0, 2'b00);
    chk("ctrl_word", ctrl_word, 32'h01E0_3C00);
    wait_b();
    vram_addr = 10'd600;
    tick();
    chk("vram_word600", vram_data, 32'h01E0_3C00);
    axi_write(12'h964, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b10);
    wait_b();
    chk("ctrl_after_slverr", ctrl_word, 32'h01E0_3C00);
    axi_read(12'h964, 32'h0000_0000, 2'b10);
    axi_read(12'hFFC, 32'h0000_0000, 2'b10);
    axi_read(12'h960, 32'h01E0_3C00, 2'b00);

    // read/write collision on word 3
    axi_write(12'h00C, 32'h0000_000A, 4'hF, 0, 0, 2'b00);
    wait_b();
    bq.push_back(2'b00);
    rq.push_back('{data: 32'h0000_000A, resp: 2'b00});
    awaddr = 12'h00C; wdata = 32'h0000_000B; wstrb = 4'hF; araddr = 12'h00C;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    axi_read(12'h00C, 32'h0000_000B, 2'b00);

    // R back-pressure
    rready = 1'b0;
    rq.push_back('{data: 32'h0000_000B, resp: 2'b00});
    issue_ar(12'h00C);
    for (int i = 0; i < 5; i++) begin
      chk("rdata_stable", rdata, 32'h0000_000B);
      chk("arready_low", 32'(arready), 32'd0);
      tick();
    end
    rready = 1'b1;
    wait_r();

    // reset mid-write: AW accepted, then reset before W
    awaddr = 12'h028; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    aresetn = 1'b0;
    tick();
    bq.delete();
    rq.delete();
    aresetn = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("no_bvalid_after_reset", 32'(bvalid), 32'd0);
      tick();
    end
    axi_read(12'h028, 32'h0000_0000, 2'b00);
    axi_read(12'h00C, 32'h0000_0000, 2'b00);
    chk("ctrl_cleared", ctrl_word, 32'd0);

    repeat (3) tick();
    chk("b_queue_drained", 32'(bq.size()), 32'd0);
    chk("r_queue_drained", 32'(rq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
